// File: rtl/button_pkg.sv
// Shared constants, FSM state codes and the wrapping value step for button_reader.
package button_pkg;
   localparam int VALUE_W = 5;

   // Board timing at 50 MHz and a short simulation-scale set
   localparam int DEF_DEBOUNCE_CYCLES = 1000000;
   localparam int DEF_HOLD_CYCLES     = 25000000;
   localparam int DEF_REPEAT_CYCLES   = 5000000;
   localparam int SIM_DEBOUNCE_CYCLES = 8;
   localparam int SIM_HOLD_CYCLES     = 40;
   localparam int SIM_REPEAT_CYCLES   = 10;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HELD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   // inc and dec together cancel; otherwise step with wrap inside 0..vmax
   function automatic logic [VALUE_W-1:0] next_value(
      input logic [VALUE_W-1:0] cur,
      input logic               inc,
      input logic               dec,
      input logic [VALUE_W-1:0] vmax
   );
      logic [VALUE_W-1:0] nxt;
      nxt = cur;
      if (inc && !dec) begin
         nxt = (cur == vmax) ? '0 : cur + VALUE_W'(1);
      end else if (dec && !inc) begin
         nxt = (cur == '0) ? vmax : cur - VALUE_W'(1);
      end
      return nxt;
   endfunction
endpackage

// File: rtl/button_reader_debounce_channel.sv
// One button: 2-flop synchroniser, debounce, hold/auto-repeat FSM; level and pulses are registered.
// Latency: raw edge to level/press/release is DEBOUNCE_CYCLES + 2 cycles; no backpressure.
module debounce_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
   parameter int ACTIVE_LOW      = 1
)(
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_but,
   output logic o_level,
   output logic o_press,
   output logic o_release,
   output logic o_repeat
);
   localparam logic RAW_IDLE = (ACTIVE_LOW != 0);
   localparam int   DB_W     = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam int   TMR_MAX  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int   TMR_W    = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [TMR_W-1:0] HOLD_LAST = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] REP_LAST  = TMR_W'(REPEAT_CYCLES - 1);

   logic [1:0]       r_sync;
   logic [DB_W-1:0]  r_db_cnt;
   logic             r_level;
   logic [1:0]       r_state;
   logic [TMR_W-1:0] r_tmr;
   logic             r_press;
   logic             r_release;
   logic             r_repeat;
   logic             w_s;
   logic             w_toggle;
   logic             w_rise;
   logic             w_fall;

   assign w_s      = r_sync[1] ^ RAW_IDLE;
   assign w_toggle = (w_s != r_level) && (r_db_cnt == DB_LAST);
   assign w_rise   = w_toggle & ~r_level;
   assign w_fall   = w_toggle & r_level;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync   <= {RAW_IDLE, RAW_IDLE};
         r_db_cnt <= '0;
         r_level  <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], i_but};
         if ((w_s == r_level) || w_toggle) begin
            r_db_cnt <= '0;
         end else begin
            r_db_cnt <= r_db_cnt + DB_W'(1);
         end
         if (w_toggle) begin
            r_level <= ~r_level;
         end
      end
   end

   // One timer serves both the initial hold delay and the repeat interval
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_tmr     <= '0;
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_repeat  <= 1'b0;
      end else begin
         r_press   <= 1'b0;
         r_release <= 1'b0;
         r_repeat  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_rise) begin
                  r_press <= 1'b1;
                  r_tmr   <= '0;
                  r_state <= ST_HELD;
               end
            end
            ST_HELD: begin
               if (w_fall) begin
                  r_release <= 1'b1;
                  r_state   <= ST_IDLE;
               end else if (r_tmr == HOLD_LAST) begin
                  r_repeat <= 1'b1;
                  r_tmr    <= '0;
                  r_state  <= ST_REPEAT;
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            ST_REPEAT: begin
               if (w_fall) begin
                  r_release <= 1'b1;
                  r_state   <= ST_IDLE;
               end else if (r_tmr == REP_LAST) begin
                  r_repeat <= 1'b1;
                  r_tmr    <= '0;
               end else begin
                  r_tmr <= r_tmr + TMR_W'(1);
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_tmr   <= '0;
            end
         endcase
      end
   end

   assign o_level   = r_level;
   assign o_press   = r_press;
   assign o_release = r_release;
   assign o_repeat  = r_repeat;
endmodule

// File: rtl/button_reader.sv
// Two debounced buttons driving a wrapping up/down digit value for a seven_seg input.
// Latency: value steps one cycle after a press/repeat pulse; no backpressure.
module button_reader
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
   parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES,
   parameter int ACTIVE_LOW      = 1,
   parameter int VALUE_MAX       = 19
)(
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_but1,
   input  logic               i_but2,
   output logic [1:0]         o_level,
   output logic [1:0]         o_press,
   output logic [1:0]         o_release,
   output logic [1:0]         o_repeat,
   output logic [VALUE_W-1:0] o_value
);
   localparam logic [VALUE_W-1:0] VMAX = VALUE_W'(VALUE_MAX);

   logic [VALUE_W-1:0] r_value;
   logic               w_inc;
   logic               w_dec;

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
   ) u_ch1 (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_but     (i_but1),
      .o_level   (o_level[0]),
      .o_press   (o_press[0]),
      .o_release (o_release[0]),
      .o_repeat  (o_repeat[0])
   );

   debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES),
      .ACTIVE_LOW      (ACTIVE_LOW)
   ) u_ch2 (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_but     (i_but2),
      .o_level   (o_level[1]),
      .o_press   (o_press[1]),
      .o_release (o_release[1]),
      .o_repeat  (o_repeat[1])
   );

   assign w_inc = o_press[0] | o_repeat[0];
   assign w_dec = o_press[1] | o_repeat[1];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_value <= '0;
      end else begin
         r_value <= next_value(r_value, w_inc, w_dec, VMAX);
      end
   end

   assign o_value = r_value;
endmodule

// File: tb/tb_button_reader.sv
// Directed bench for button_reader at simulation timing 8/40/10, active-low buttons.
module tb_button_reader;
   import button_pkg::*;

   logic       clk;
   logic       rst;
   logic       but1;
   logic       but2;
   logic [1:0] level;
   logic [1:0] press;
   logic [1:0] rel;
   logic [1:0] rpt;
   logic [4:0] value;

   int checks   = 0;
   int failures = 0;

   button_reader #(
      .DEBOUNCE_CYCLES (SIM_DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (SIM_HOLD_CYCLES),
      .REPEAT_CYCLES   (SIM_REPEAT_CYCLES),
      .ACTIVE_LOW      (1),
      .VALUE_MAX       (19)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_but1    (but1),
      .i_but2    (but2),
      .o_level   (level),
      .o_press   (press),
      .o_release (rel),
      .o_repeat  (rpt),
      .o_value   (value)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish (time %0t)", $time);
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic apply_reset();
      rst  = 1'b1;
      but1 = 1'b1;
      but2 = 1'b1;
      ticks(3);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst  = 1'b1;
      but1 = 1'b0;
      but2 = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({level, press, rel, rpt, value} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want 0", {level, press, rel, rpt, value});
         end
      end
      rst = 1'b0;
      ticks(9);
      checks++;
      if (press !== 2'b00 || level !== 2'b00) begin
         failures++;
         $display("FAIL reset_early_press: press=%b level=%b want 00/00", press, level);
      end
      tick();
      checks++;
      if (press !== 2'b11 || level !== 2'b11) begin
         failures++;
         $display("FAIL reset_press_at_10: press=%b level=%b want 11/11", press, level);
      end
      tick();
      checks++;
      if (value !== 5'd0 || press !== 2'b00) begin
         failures++;
         $display("FAIL reset_cancel: value=%0d press=%b want 0/00", value, press);
      end
      but1 = 1'b1;
      but2 = 1'b1;
      ticks(10);
      checks++;
      if (rel !== 2'b11) begin
         failures++;
         $display("FAIL reset_release: release=%b want 11", rel);
      end
   endtask

   task automatic test_bounce();
      logic [1:0] seen;
      int lows [4] = '{5, 5, 7, 5};
      apply_reset();
      seen = 2'b00;
      for (int p = 0; p < 4; p++) begin
         but1 = 1'b0;
         for (int i = 0; i < lows[p]; i++) begin
            tick();
            seen = seen | press | level | rel | rpt;
         end
         but1 = 1'b1;
         for (int i = 0; i < 3; i++) begin
            tick();
            seen = seen | press | level | rel | rpt;
         end
      end
      checks++;
      if (seen !== 2'b00) begin
         failures++;
         $display("FAIL bounce_no_event: seen=%b want 00", seen);
      end
      but1 = 1'b0;
      ticks(9);
      checks++;
      if (press !== 2'b00) begin
         failures++;
         $display("FAIL bounce_early: press=%b want 00", press);
      end
      tick();
      checks++;
      if (press !== 2'b01 || value !== 5'd0) begin
         failures++;
         $display("FAIL bounce_press: press=%b value=%0d want 01/0", press, value);
      end
      tick();
      checks++;
      if (value !== 5'd1) begin
         failures++;
         $display("FAIL bounce_value: value=%0d want 1", value);
      end
   endtask

   task automatic test_auto_repeat();
      int errs;
      int nrep;
      logic exp_rpt;
      apply_reset();
      but1 = 1'b0;
      ticks(10);
      checks++;
      if (press !== 2'b01) begin
         failures++;
         $display("FAIL ar_press: press=%b want 01", press);
      end
      errs = 0;
      nrep = 0;
      for (int t = 1; t <= 105; t++) begin
         tick();
         exp_rpt = (t >= 40) && (t <= 100) && (t % 10 == 0);
         if (rpt[0] !== exp_rpt) errs++;
         if (rpt[0] === 1'b1) nrep++;
         if (t < 105 && rel[0] !== 1'b0) errs++;
         if (t == 95) but1 = 1'b1;
      end
      checks++;
      if (errs !== 0) begin
         failures++;
         $display("FAIL ar_repeat_timing: mismatched cycles=%0d want 0", errs);
      end
      checks++;
      if (nrep !== 7) begin
         failures++;
         $display("FAIL ar_repeat_count: got %0d want 7", nrep);
      end
      checks++;
      if (rel !== 2'b01 || level !== 2'b00) begin
         failures++;
         $display("FAIL ar_release: release=%b level=%b want 01/00", rel, level);
      end
      tick();
      checks++;
      if (value !== 5'd8) begin
         failures++;
         $display("FAIL ar_value: value=%0d want 8", value);
      end
   endtask

   task automatic test_release_vs_repeat();
      apply_reset();
      but1 = 1'b0;
      ticks(10);
      for (int t = 1; t <= 110; t++) begin
         tick();
         if (t == 100) begin
            checks++;
            if (rpt[0] !== 1'b1) begin
               failures++;
               $display("FAIL rvr_repeat_100: repeat=%b want 1", rpt[0]);
            end
            but1 = 1'b1;
         end
      end
      checks++;
      if (rel[0] !== 1'b1 || rpt[0] !== 1'b0) begin
         failures++;
         $display("FAIL rvr_priority: release=%b repeat=%b want 1/0", rel[0], rpt[0]);
      end
      tick();
      checks++;
      if (value !== 5'd8) begin
         failures++;
         $display("FAIL rvr_value: value=%0d want 8", value);
      end
   endtask

   task automatic test_wrap();
      apply_reset();
      but2 = 1'b0;
      ticks(10);
      checks++;
      if (press !== 2'b10) begin
         failures++;
         $display("FAIL wrap_dec_press: press=%b want 10", press);
      end
      but2 = 1'b1;
      tick();
      checks++;
      if (value !== 5'd19) begin
         failures++;
         $display("FAIL wrap_down: value=%0d want 19", value);
      end
      ticks(9);
      checks++;
      if (rel !== 2'b10) begin
         failures++;
         $display("FAIL wrap_dec_release: release=%b want 10", rel);
      end
      ticks(2);
      but1 = 1'b0;
      ticks(10);
      but1 = 1'b1;
      tick();
      checks++;
      if (value !== 5'd0) begin
         failures++;
         $display("FAIL wrap_up: value=%0d want 0", value);
      end
      ticks(12);
   endtask

   task automatic test_simultaneous();
      but1 = 1'b0;
      but2 = 1'b0;
      ticks(10);
      checks++;
      if (press !== 2'b11) begin
         failures++;
         $display("FAIL sim_press: press=%b want 11", press);
      end
      but1 = 1'b1;
      but2 = 1'b1;
      tick();
      checks++;
      if (value !== 5'd0) begin
         failures++;
         $display("FAIL sim_value: value=%0d want 0", value);
      end
      ticks(9);
      checks++;
      if (rel !== 2'b11) begin
         failures++;
         $display("FAIL sim_release: release=%b want 11", rel);
      end
   endtask

   initial begin
      rst  = 1'b1;
      but1 = 1'b0;
      but2 = 1'b0;
      test_reset();
      test_bounce();
      test_auto_repeat();
      test_release_vs_repeat();
      test_wrap();
      test_simultaneous();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
